mu0_param: RTL and testbench
============================

# mu0_param

Parametrised next-generation MU0 core: a single-accumulator, two-phase (fetch/execute) processor with configurable data width. It adds a memory-ready stall handshake, a carry flag, immediate/logic/borrow-aware instructions and an explicit halted state. It sits between the system memory/bus interface and the observability/debug harness, as a drop-in replacement for the 16-bit core when `DATA_W=16`.

## Interface
- `DATA_W`, 16: accumulator/instruction width, ≥8. Opcode is always the top 4 bits.
- `ADDR_W`, `DATA_W-4`: address/operand width, fixed as `DATA_W-4`. Any other value is an elaboration error.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `data_in` in `DATA_W`: memory read data, valid when `mem_ready`=1.
- `mem_ready` in 1: memory completes the current access this cycle.
- `data_out` out `DATA_W`: always equals `acc`.
- `address` out `ADDR_W`: memory address.
- `memory_read` out 1: read request.
- `memory_write` out 1: write request.
- `fetch` out 1: state is FETCH.
- `halted` out 1: state is HALT.
- `acc` out `DATA_W`: accumulator.
- `pc` out `ADDR_W`: program counter.
- `flags` out 3: {C, N, Z}. Z = acc==0, N = acc[MSB], C = registered carry.

## Operation
- States:
  - FETCH: address=pc, read=1.
  - EXECUTE: address=operand; read/write per opcode.
  - HALT: read=write=0, address=pc.
- Memory outputs are combinational from state and ir. They must hold stable while stalled.
- Opcodes (operand = ir[ADDR_W-1:0]):
  - 0 LDA: acc←mem.
  - 1 STA: mem←acc.
  - 2 ADD: acc←acc+mem, C←carry out.
  - 3 SUB: acc←acc−mem, C←1 iff acc≥mem (unsigned, no borrow).
  - 4 JMP.
  - 5 JGE: jump if N=0.
  - 6 JNE: jump if Z=0.
  - 7 STP: go to HALT.
  - 8 LDI: acc←zero-extended operand, no memory access.
  - 9 AND: acc←acc&mem.
  - A OR: acc←acc|mem.
  - B ADC: acc←acc+mem+C, C←carry out.
  - C JCS: jump if C=1.
  - D–F: no-op, 2 cycles.
- Only ADD, SUB and ADC update C. All other instructions preserve it.
- Arithmetic wraps modulo 2^DATA_W. pc increment wraps from all-ones to 0.
- Stall rule: in FETCH, or in EXECUTE with read or write asserted, if `mem_ready`=0 then no register changes. The same state and outputs are repeated next cycle. Non-memory EXECUTE ignores `mem_ready`.
- FETCH completion: ir←data_in, pc←pc+1, go to EXECUTE.
- EXECUTE completion: go to FETCH, except STP goes to HALT.
- HALT is left only by `rst`.

## Timing
- Reset, sampled on the `clk` edge:
  - pc=0, acc=0, ir=0, C=0, state=FETCH.
  - After that edge: address=0, memory_read=1, memory_write=0, fetch=1, halted=0, flags=3'b001.
- Reset has priority over everything, including a stalled access or HALT. It aborts mid-instruction with no partial update.
- With `mem_ready` held at 1, every instruction takes exactly 2 cycles. Each stalled cycle adds 1.
- `acc`, `pc` and `flags` update on the edge that ends the completing EXECUTE cycle.
- STA asserts `memory_write` for exactly the cycles spent in its EXECUTE state.

## Structure
- Shared package `mu0_pkg`:
  - opcode constants (`OP_LDA`..`OP_JCS`)
  - state encoding (FETCH, EXECUTE, HALT)
  - flag bit indices
- One sub-module, `mu0_alu`: combinational, `DATA_W`-parametrised. Takes acc, mem, C and opcode; returns result and carry.
- The control FSM and registers stay in `mu0_param`.

## Test plan
- Reset then `mem_ready`=1, memory [0]=LDA 5, [1]=ADD 6, [2]=STA 7, [3]=STP, [5]=0x1234, [6]=0x0001 → write of 0x1235 to address 7 at cycle 6, then `halted`=1 and pc=4.
- ADC chain, DATA_W=16: LDA of 0xFFFF, ADD of 0x0001 → acc=0, flags=3'b101. Then ADC of 0x0000 → acc=1, C=0.
- SUB 5−7 → acc=0xFFFE, C=0, N=1. Then JCS not taken and JGE not taken. SUB 7−5 → C=1 and JCS taken.
- Hold `mem_ready`=0 for 3 cycles during an LDA execute → address, memory_read and acc stay stable throughout, and the instruction completes in 5 cycles.
- Assert `rst` while halted and while stalled mid-STA → memory_write drops the next cycle, pc=0, acc=0, fetch=1.
- DATA_W=24 build: LDI 0xABC → acc=0x000ABC. Then run a pc wrap from 0xFFFFF to 0 → the next fetch reads address 0.

Source files
------------

// File: rtl/mu0_pkg.sv
// mu0_pkg: shared definitions for the parametrised MU0 core.
//   - 4-bit opcode constants (opcode is always the top nibble of ir)
//   - control state encoding
//   - bit positions inside the {C, N, Z} flags bus
package mu0_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_AND = 4'h9;
  localparam logic [3:0] OP_OR  = 4'hA;
  localparam logic [3:0] OP_ADC = 4'hB;
  localparam logic [3:0] OP_JCS = 4'hC;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  // Opcodes whose EXECUTE phase reads memory.
  function automatic logic op_reads(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR)  || (op == OP_ADC);
  endfunction

endpackage

// File: rtl/mu0_alu.sv
// mu0_alu: combinational accumulator datapath.
// Ports:
//   i_acc    current accumulator
//   i_mem    memory operand (or zero-extended immediate for LDI)
//   i_c      current carry flag
//   i_op     opcode
//   o_result new accumulator value (only meaningful for acc-writing ops)
//   o_carry  new carry (equals i_c for ops that do not touch C)
module mu0_alu
  import mu0_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_mem,
  input  logic              i_c,
  input  logic [3:0]        i_op,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry
);

  logic [DATA_W:0] w_sum;

  always_comb begin
    w_sum    = '0;
    o_result = i_mem;
    o_carry  = i_c;
    case (i_op)
      OP_ADD: begin
        w_sum    = {1'b0, i_acc} + {1'b0, i_mem};
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
      end
      OP_ADC: begin
        w_sum    = {1'b0, i_acc} + {1'b0, i_mem} + {{DATA_W{1'b0}}, i_c};
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
      end
      OP_SUB: begin
        // C is "no borrow": set when the unsigned subtraction does not wrap.
        o_result = i_acc - i_mem;
        o_carry  = (i_acc >= i_mem);
      end
      OP_AND:  o_result = i_acc & i_mem;
      OP_OR:   o_result = i_acc | i_mem;
      default: o_result = i_mem;  // LDA / LDI pass the operand through
    endcase
  end

endmodule

// File: rtl/mu0_param.sv
// mu0_param: parametrised two-phase (fetch/execute) MU0 accumulator core
// with memory-ready stalls, carry flag and an explicit HALT state.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   data_in         memory read data, valid when mem_ready=1
//   mem_ready       memory completes the current access this cycle
//   data_out        write data (always the accumulator)
//   address         memory address (pc in FETCH/HALT, operand in EXECUTE)
//   memory_read     read request
//   memory_write    write request (STA execute)
//   fetch, halted   state is FETCH / HALT
//   acc, pc         architectural registers
//   flags           {C, N, Z}
module mu0_param
  import mu0_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = DATA_W - 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] address,
  output logic              memory_read,
  output logic              memory_write,
  output logic              fetch,
  output logic              halted,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        flags
);

  if (ADDR_W != DATA_W - 4) begin : g_bad_addr_w
    $error("mu0_param: ADDR_W must equal DATA_W-4");
  end
  if (DATA_W < 8) begin : g_bad_data_w
    $error("mu0_param: DATA_W must be at least 8");
  end

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_ir, r_acc;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_c;

  logic [3:0]          w_op;
  logic [ADDR_W-1:0]   w_opd;
  logic                w_stall, w_jump, w_acc_we, w_c_we;
  logic [DATA_W-1:0]   w_alu_mem, w_alu_res;
  logic                w_alu_c;

  assign w_op  = r_ir[DATA_W-1 -: 4];
  assign w_opd = r_ir[ADDR_W-1:0];

  // A pending memory access without mem_ready freezes every register.
  // HALT and non-memory EXECUTE never request, so they never stall.
  assign w_stall = (memory_read | memory_write) & ~mem_ready;

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_next;
  end

  // ---- next state ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH: if (!w_stall) w_next = ST_EXEC;
      ST_EXEC:  if (!w_stall) w_next = (w_op == OP_STP) ? ST_HALT : ST_FETCH;
      default:  w_next = ST_HALT;
    endcase
  end

  // ---- outputs (pure function of state and ir, so stable across stalls) ----
  always_comb begin
    address      = r_pc;
    memory_read  = 1'b0;
    memory_write = 1'b0;
    fetch        = 1'b0;
    halted       = 1'b0;
    case (r_state)
      ST_FETCH: begin
        memory_read = 1'b1;
        fetch       = 1'b1;
      end
      ST_EXEC: begin
        address      = w_opd;
        memory_read  = op_reads(w_op);
        memory_write = (w_op == OP_STA);
      end
      default: halted = 1'b1;
    endcase
  end

  // ---- datapath ----
  assign w_alu_mem = (w_op == OP_LDI) ? DATA_W'(w_opd) : data_in;

  mu0_alu #(.DATA_W(DATA_W)) u_alu (
    .i_acc    (r_acc),
    .i_mem    (w_alu_mem),
    .i_c      (r_c),
    .i_op     (w_op),
    .o_result (w_alu_res),
    .o_carry  (w_alu_c)
  );

  always_comb begin
    w_acc_we = op_reads(w_op) || (w_op == OP_LDI);
    w_c_we   = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_ADC);
    case (w_op)
      OP_JMP:  w_jump = 1'b1;
      OP_JGE:  w_jump = ~r_acc[DATA_W-1];
      OP_JNE:  w_jump = |r_acc;
      OP_JCS:  w_jump = r_c;
      default: w_jump = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir  <= '0;
      r_pc  <= '0;
      r_acc <= '0;
      r_c   <= 1'b0;
    end else if (!w_stall) begin
      case (r_state)
        ST_FETCH: begin
          r_ir <= data_in;
          r_pc <= r_pc + ADDR_W'(1);
        end
        ST_EXEC: begin
          if (w_acc_we) r_acc <= w_alu_res;
          if (w_c_we)   r_c   <= w_alu_c;
          if (w_jump)   r_pc  <= w_opd;
        end
        default: ;
      endcase
    end
  end

  assign data_out = r_acc;
  assign acc      = r_acc;
  assign pc       = r_pc;
  assign flags    = {r_c, r_acc[DATA_W-1], (r_acc == '0)};

endmodule

// File: tb/tb_mu0_param.sv
module tb_mu0_param;

  localparam int MAXK = 400;
  localparam int MSZ  = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- 16-bit DUT ----------------
  logic [15:0] data_in, data_out, acc;
  logic [11:0] address, pc;
  logic        mem_ready = 1'b1;
  logic        memory_read, memory_write, fetch, halted;
  logic [2:0]  flags;
  logic [15:0] dm [0:MSZ-1];

  assign data_in = dm[address];

  mu0_param #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .mem_ready(mem_ready),
    .data_out(data_out), .address(address), .memory_read(memory_read),
    .memory_write(memory_write), .fetch(fetch), .halted(halted),
    .acc(acc), .pc(pc), .flags(flags)
  );

  // ---------------- 24-bit DUT ----------------
  logic [23:0] d24_in, d24_out, acc24;
  logic [19:0] a24, pc24;
  logic        rdy24 = 1'b1;
  logic        rd24, wr24, f24, h24;
  logic [2:0]  flg24;

  // Tiny ROM: [0]=LDI 0xABC, [1]=JMP 0xFFFFF, [0xFFFFF]=no-op (opcode D)
  always_comb begin
    d24_in = 24'h0;
    if (a24 == 20'h00000)      d24_in = 24'h800ABC;
    else if (a24 == 20'h00001) d24_in = 24'h4FFFFF;
    else if (a24 == 20'hFFFFF) d24_in = 24'hD00000;
  end

  mu0_param #(.DATA_W(24)) dut24 (
    .clk(clk), .rst(rst), .data_in(d24_in), .mem_ready(rdy24),
    .data_out(d24_out), .address(a24), .memory_read(rd24),
    .memory_write(wr24), .fetch(f24), .halted(h24),
    .acc(acc24), .pc(pc24), .flags(flg24)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus / reference model ----------------
  int pm [0:MSZ-1];       // program image
  int mm [0:MSZ-1];       // model memory
  bit rdy [0:MAXK-1];     // mem_ready per cycle

  // Expected per-cycle observation
  int e_addr[0:MAXK-1], e_acc[0:MAXK-1], e_pc[0:MAXK-1], e_flg[0:MAXK-1];
  bit e_rd[0:MAXK-1], e_wr[0:MAXK-1], e_f[0:MAXK-1], e_h[0:MAXK-1];
  // Sampled per-cycle observation for directed checks
  int s_addr[0:MAXK-1], s_acc[0:MAXK-1], s_pc[0:MAXK-1], s_flg[0:MAXK-1];
  bit s_rd[0:MAXK-1], s_wr[0:MAXK-1], s_f[0:MAXK-1], s_h[0:MAXK-1];

  int macc, mpc, mc;
  bit mh;

  task automatic rec(input int t, input int a, input bit r, input bit w, input bit f, input bit h);
    e_addr[t] = a; e_rd[t] = r; e_wr[t] = w; e_f[t] = f; e_h[t] = h;
    e_acc[t] = macc; e_pc[t] = mpc;
    e_flg[t] = (mc << 2) | (((macc >> 15) & 1) << 1) | ((macc == 0) ? 1 : 0);
  endtask

  // Instruction-level ISA model; each instruction is a fetch that waits for
  // a ready cycle, then an execute that waits only if it touches memory.
  task automatic model(input int k);
    int t, ir, op, opd, m, s;
    bit ok, memop;
    for (int i = 0; i < MSZ; i++) mm[i] = pm[i];
    macc = 0; mpc = 0; mc = 0; mh = 0; t = 0;
    while (t < k) begin
      if (mh) begin rec(t, mpc, 0, 0, 0, 1); t++; continue; end
      ok = 0;
      while (t < k && !ok) begin rec(t, mpc, 1, 0, 1, 0); ok = rdy[t]; t++; end
      if (!ok) break;
      ir = mm[mpc]; mpc = (mpc + 1) % MSZ;
      op = (ir >> 12) & 15; opd = ir & 'hFFF;
      memop = (op == 0 || op == 1 || op == 2 || op == 3 || op == 9 || op == 10 || op == 11);
      ok = 0;
      while (t < k && !ok) begin
        rec(t, opd, memop && op != 1, op == 1, 0, 0);
        ok = rdy[t] || !memop; t++;
      end
      if (!ok) break;
      m = mm[opd];
      case (op)
        0:  macc = m;
        1:  mm[opd] = macc;
        2:  begin s = macc + m; macc = s % 65536; mc = s / 65536; end
        3:  begin mc = (macc >= m) ? 1 : 0; macc = (macc - m + 65536) % 65536; end
        4:  mpc = opd;
        5:  if (macc < 32768) mpc = opd;
        6:  if (macc != 0) mpc = opd;
        7:  mh = 1;
        8:  macc = opd;
        9:  macc = macc & m;
        10: macc = macc | m;
        11: begin s = macc + m + mc; macc = s % 65536; mc = s / 65536; end
        12: if (mc != 0) mpc = opd;
        default: ;
      endcase
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < MSZ; i++) pm[i] = 0;
    for (int i = 0; i < MAXK; i++) rdy[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Load, reset, run k cycles comparing every cycle against the model.
  task automatic run(input string nm, input int k);
    for (int i = 0; i < MSZ; i++) dm[i] = pm[i][15:0];
    model(k);
    do_reset();
    for (int c = 0; c < k; c++) begin
      mem_ready = rdy[c];
      @(negedge clk);
      s_addr[c] = address; s_rd[c] = memory_read; s_wr[c] = memory_write;
      s_f[c] = fetch; s_h[c] = halted; s_acc[c] = data_out; s_pc[c] = pc; s_flg[c] = flags;
      chk($sformatf("%s_c%0d_addr", nm, c), address, e_addr[c]);
      chk($sformatf("%s_c%0d_rd", nm, c), memory_read, e_rd[c]);
      chk($sformatf("%s_c%0d_wr", nm, c), memory_write, e_wr[c]);
      chk($sformatf("%s_c%0d_fetch", nm, c), fetch, e_f[c]);
      chk($sformatf("%s_c%0d_halt", nm, c), halted, e_h[c]);
      chk($sformatf("%s_c%0d_acc", nm, c), acc, e_acc[c]);
      chk($sformatf("%s_c%0d_dout", nm, c), data_out, e_acc[c]);
      chk($sformatf("%s_c%0d_pc", nm, c), pc, e_pc[c]);
      chk($sformatf("%s_c%0d_flags", nm, c), flags, e_flg[c]);
      if (memory_write && mem_ready) dm[address] = data_out;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // ---- reset state + 24-bit build: LDI and pc wrap ----
    mem_ready = 1'b0;
    do_reset();
    chk("rst_addr", address, 0);
    chk("rst_rd", memory_read, 1);
    chk("rst_wr", memory_write, 0);
    chk("rst_fetch", fetch, 1);
    chk("rst_halt", halted, 0);
    chk("rst_flags", flags, 3'b001);
    chk("rst_acc", acc, 0);
    chk("rst_pc", pc, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin chk("w24_addr0", a24, 0); chk("w24_fetch0", f24, 1); end
      if (c == 2) chk("w24_ldi", acc24, 24'h000ABC);
      if (c == 4) begin chk("w24_addr_top", a24, 20'hFFFFF); chk("w24_fetch4", f24, 1); end
      if (c == 5) chk("w24_pc_wrap", pc24, 0);
      if (c == 6) begin
        chk("w24_addr_wrap", a24, 0);
        chk("w24_fetch6", f24, 1);
        chk("w24_acc6", acc24, 24'h000ABC);
      end
      @(posedge clk); #1;
    end

    // ---- LDA/ADD/STA/STP ----
    clear_prog();
    pm[0] = 'h0005; pm[1] = 'h2006; pm[2] = 'h1007; pm[3] = 'h7000;
    pm[5] = 'h1234; pm[6] = 'h0001;
    run("basic", 12);
    chk("basic_wr6", s_wr[5], 1);
    chk("basic_wr6_addr", s_addr[5], 7);
    chk("basic_wr6_data", s_acc[5], 'h1235);
    chk("basic_mem7", dm[7], 'h1235);
    chk("basic_halt", s_h[8], 1);
    chk("basic_pc", s_pc[8], 4);
    // reset while halted
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rsth_halt", halted, 0);
    chk("rsth_fetch", fetch, 1);
    chk("rsth_pc", pc, 0);
    chk("rsth_acc", acc, 0);
    rst = 1'b0;

    // ---- ADD carry then ADC ----
    clear_prog();
    pm[0] = 'h000A; pm[1] = 'h200B; pm[2] = 'hB00C; pm[3] = 'h7000;
    pm[10] = 'hFFFF; pm[11] = 'h0001; pm[12] = 'h0000;
    run("adc", 10);
    chk("adc_acc0", s_acc[4], 0);
    chk("adc_flags101", s_flg[4], 3'b101);
    chk("adc_acc1", s_acc[6], 1);
    chk("adc_flags", s_flg[6], 3'b000);

    // ---- SUB / JCS / JGE ----
    clear_prog();
    pm[0] = 'h0014; pm[1] = 'h3015; pm[2] = 'hC008; pm[3] = 'h5008;
    pm[4] = 'h0015; pm[5] = 'h3014; pm[6] = 'hC009; pm[7] = 'h7000;
    pm[8] = 'h7000; pm[9] = 'h8077; pm[10] = 'h7000;
    pm[20] = 5; pm[21] = 7;
    run("sub", 20);
    chk("sub_acc", s_acc[4], 'hFFFE);
    chk("sub_flags", s_flg[4], 3'b010);
    chk("sub_jcs_nt", s_pc[6], 3);
    chk("sub_jge_nt", s_pc[8], 4);
    chk("sub2_acc", s_acc[12], 2);
    chk("sub2_flags", s_flg[12], 3'b100);
    chk("sub_jcs_t", s_pc[14], 9);
    chk("sub_ldi", s_acc[16], 'h77);

    // ---- 3-cycle stall during LDA execute ----
    clear_prog();
    pm[0] = 'h0005; pm[1] = 'h7000; pm[5] = 'h00AA;
    rdy[1] = 0; rdy[2] = 0; rdy[3] = 0;
    run("stall", 8);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("stall_addr%0d", c), s_addr[c], 5);
      chk($sformatf("stall_rd%0d", c), s_rd[c], 1);
      chk($sformatf("stall_acc%0d", c), s_acc[c], 0);
    end
    chk("stall_done_acc", s_acc[5], 'hAA);
    chk("stall_done_fetch", s_f[5], 1);
    chk("stall_done_addr", s_addr[5], 1);

    // ---- reset while stalled mid-STA ----
    clear_prog();
    pm[0] = 'h8003; pm[1] = 'h1009;
    rdy[1] = 0;
    for (int c = 3; c < MAXK; c++) rdy[c] = 0;
    run("rsts", 5);
    mem_ready = 1'b0;
    chk("rsts_wr_before", memory_write, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rsts_wr_after", memory_write, 0);
    chk("rsts_pc", pc, 0);
    chk("rsts_acc", acc, 0);
    chk("rsts_fetch", fetch, 1);
    chk("rsts_mem9", dm[9], 0);
    rst = 1'b0;

    // ---- random programs with random mem_ready ----
    for (int p = 0; p < 4; p++) begin
      clear_prog();
      for (int i = 0; i < 64; i++)
        pm[i] = (int'($urandom_range(0, 15)) << 12) | int'($urandom_range(0, 63));
      for (int c = 0; c < MAXK; c++) rdy[c] = ($urandom_range(0, 9) < 7);
      run($sformatf("rnd%0d", p), 300);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
